// File: rtl/vend_controller.sv
// Vending-machine transaction sequencer: accumulates credit and selection from keypad
// strobes, checks price on confirm, times dispense/error phases and reports change.
module vend_controller #(
    parameter logic [7:0]  PRICE_1     = 8'd15,
    parameter logic [7:0]  PRICE_2     = 8'd20,
    parameter logic [7:0]  PRICE_3     = 8'd25,
    parameter logic [7:0]  PRICE_4     = 8'd30,
    parameter logic [7:0]  PRICE_5     = 8'd45,
    parameter logic [7:0]  MAX_CREDIT  = 8'd200,
    parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] sum,
    output logic [2:0] candy_sum,
    output logic       dispense,
    output logic [2:0] dispense_id,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       coin_reject,
    output logic       err,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE, S_ERROR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sum_q, sum_d;
    logic [2:0]  candy_q, candy_d;
    logic        dispense_q, dispense_d;
    logic [2:0]  dispense_id_q, dispense_id_d;
    logic        change_valid_q, change_valid_d;
    logic [7:0]  change_amt_q, change_amt_d;
    logic        coin_reject_q, coin_reject_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [15:0] timer_q, timer_d;

    logic       is_coin, is_sel, is_cancel, is_confirm, has_sel;
    logic [7:0] coin_val, price;
    logic [8:0] credit_sum;

    always_comb begin
        is_coin  = 1'b1;
        coin_val = 8'd0;
        case (key_code)
            4'hA:    coin_val = 8'd5;
            4'hB:    coin_val = 8'd10;
            4'hC:    coin_val = 8'd25;
            default: is_coin = 1'b0;
        endcase
        is_sel     = (key_code >= 4'd1) && (key_code <= 4'd5);
        is_cancel  = (key_code == 4'hE);
        is_confirm = (key_code == 4'hF);
        credit_sum = {1'b0, sum_q} + {1'b0, coin_val};
    end

    // Indices outside 1..5 count as no selection and carry no price.
    always_comb begin
        has_sel = 1'b1;
        price   = 8'd0;
        case (candy_q)
            3'd1:    price = PRICE_1;
            3'd2:    price = PRICE_2;
            3'd3:    price = PRICE_3;
            3'd4:    price = PRICE_4;
            3'd5:    price = PRICE_5;
            default: has_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        candy_d        = candy_q;
        dispense_d     = 1'b0;
        dispense_id_d  = dispense_id_q;
        change_valid_d = 1'b0;
        change_amt_d   = change_amt_q;
        coin_reject_d  = 1'b0;
        timer_d        = timer_q;
        case (state_q)
            S_IDLE: if (key_valid) begin
                if (is_coin) begin
                    sum_d   = coin_val;
                    state_d = S_CREDIT;
                end else if (is_sel) begin
                    candy_d = key_code[2:0];
                end else if (is_cancel) begin
                    candy_d = 3'd0;
                end
            end
            S_CREDIT: if (key_valid) begin
                if (is_coin) begin
                    if (credit_sum <= {1'b0, MAX_CREDIT}) sum_d = credit_sum[7:0];
                    else                                  coin_reject_d = 1'b1;
                end else if (is_sel) begin
                    candy_d = key_code[2:0];
                end else if (is_cancel) begin
                    change_amt_d   = sum_q;
                    change_valid_d = (sum_q != 8'd0);
                    candy_d        = 3'd0;
                    state_d        = S_CHANGE;
                end else if (is_confirm) begin
                    timer_d = HOLD_CYCLES - 16'd1;
                    if (!has_sel || sum_q < price) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d       = S_DISPENSE;
                        dispense_d    = 1'b1;
                        dispense_id_d = candy_q;
                        sum_d         = sum_q - price;
                    end
                end
            end
            S_DISPENSE: if (timer_q == 16'd0) begin
                state_d        = S_CHANGE;
                change_amt_d   = sum_q;
                change_valid_d = (sum_q != 8'd0);
            end else begin
                timer_d = timer_q - 16'd1;
            end
            S_CHANGE: begin
                sum_d   = 8'd0;
                candy_d = 3'd0;
                state_d = S_IDLE;
            end
            S_ERROR: if (timer_q == 16'd0) state_d = S_CREDIT;
                     else                  timer_d = timer_q - 16'd1;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE) || (state_d == S_ERROR);
        err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sum_q          <= 8'd0;
            candy_q        <= 3'd0;
            dispense_q     <= 1'b0;
            dispense_id_q  <= 3'd0;
            change_valid_q <= 1'b0;
            change_amt_q   <= 8'd0;
            coin_reject_q  <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            timer_q        <= 16'd0;
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            candy_q        <= candy_d;
            dispense_q     <= dispense_d;
            dispense_id_q  <= dispense_id_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            timer_q        <= timer_d;
        end
    end

    assign sum          = sum_q;
    assign candy_sum    = candy_q;
    assign dispense     = dispense_q;
    assign dispense_id  = dispense_id_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign err          = err_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: a per-cycle reference model of the vending
// transaction rules plus literal spot checks at the interesting points.
module tb_vend_controller;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset, key_valid;
    logic [3:0] key_code;
    logic [7:0] sum, change_amt;
    logic [2:0] candy_sum, dispense_id;
    logic       dispense, change_valid, coin_reject, err, busy;

    vend_controller #(.HOLD_CYCLES(16'(HOLD))) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .sum(sum), .candy_sum(candy_sum), .dispense(dispense), .dispense_id(dispense_id),
        .change_valid(change_valid), .change_amt(change_amt), .coin_reject(coin_reject),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase names and a spent-cycle counter, prices from a table.
    localparam int P_IDLE = 0, P_CREDIT = 1, P_DISP = 2, P_CHANGE = 3, P_ERR = 4;
    int price_tab [0:7] = '{0, 15, 20, 25, 30, 45, 0, 0};
    int m_phase = P_IDLE, m_credit = 0, m_sel = 0, m_spent = 0;
    int e_disp = 0, e_id = 0, e_cv = 0, e_amt = 0, e_rej = 0;
    bit m_valid = 1'b0;

    function automatic int coin_of(input logic [3:0] k);
        case (k)
            4'hA:    return 5;
            4'hB:    return 10;
            4'hC:    return 25;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int c;
        int k;
        k = int'(key_code);
        c = coin_of(key_code);
        e_disp = 0; e_cv = 0; e_rej = 0;
        if (reset) begin
            m_phase = P_IDLE; m_credit = 0; m_sel = 0; m_spent = 0; e_amt = 0; e_id = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (key_valid) begin
                    if (c != 0) begin m_credit = c; m_phase = P_CREDIT; end
                    else if (k >= 1 && k <= 5) m_sel = k;
                    else if (k == 14) m_sel = 0;
                end
                P_CREDIT: if (key_valid) begin
                    if (c != 0) begin
                        if (m_credit + c <= 200) m_credit += c;
                        else e_rej = 1;
                    end else if (k >= 1 && k <= 5) m_sel = k;
                    else if (k == 14) begin
                        e_amt = m_credit; e_cv = (m_credit != 0); m_sel = 0; m_phase = P_CHANGE;
                    end else if (k == 15) begin
                        m_spent = 0;
                        if (price_tab[m_sel] == 0 || m_credit < price_tab[m_sel]) m_phase = P_ERR;
                        else begin
                            m_phase = P_DISP; e_disp = 1; e_id = m_sel;
                            m_credit -= price_tab[m_sel];
                        end
                    end
                end
                P_DISP: begin
                    m_spent++;
                    if (m_spent == HOLD) begin
                        m_phase = P_CHANGE; e_amt = m_credit; e_cv = (m_credit != 0);
                    end
                end
                P_CHANGE: begin m_credit = 0; m_sel = 0; m_phase = P_IDLE; end
                default: begin
                    m_spent++;
                    if (m_spent == HOLD) m_phase = P_CREDIT;
                end
            endcase
        end
        m_valid = 1'b1;
    endtask

    // Inputs change just after posedge, so at negedge they are exactly what the next edge samples.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("sum", int'(sum), m_credit);
            chk("candy_sum", int'(candy_sum), m_sel);
            chk("busy", int'(busy), int'(m_phase == P_DISP || m_phase == P_CHANGE || m_phase == P_ERR));
            chk("err", int'(err), int'(m_phase == P_ERR));
            chk("dispense", int'(dispense), e_disp);
            if (e_disp != 0) chk("dispense_id", int'(dispense_id), e_id);
            chk("change_valid", int'(change_valid), e_cv);
            chk("change_amt", int'(change_amt), e_amt);
            chk("coin_reject", int'(coin_reject), e_rej);
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic wait_idle(output int saw_cv);
        int n;
        saw_cv = 0;
        n = 0;
        while (busy && n < 100) begin
            if (change_valid) saw_cv = 1;
            tick();
            n++;
        end
        chk("idle_timeout", int'(n < 100), 1);
    endtask

    initial begin
        int n;
        int found;
        int saw;
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        tick();
        chk("rst_sum", int'(sum), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cv", int'(change_valid), 0);
        tick();
        reset = 1'b0;
        tick();

        // IDLE housekeeping: select, cancel, confirm and ignored code
        press(4'h4); chk("idle_sel", int'(candy_sum), 4);
        press(4'hF); chk("idle_f_busy", int'(busy), 0);
        press(4'hE); chk("idle_clr", int'(candy_sum), 0);
        press(4'hD); chk("idle_d_sum", int'(sum), 0);

        // Underfunded confirm -> ERROR for HOLD cycles, credit preserved
        press(4'hA); chk("coin_a", int'(sum), 5);
        chk("model_credit", m_credit, 5);
        press(4'h3);
        press(4'hF); chk("err_hi", int'(err), 1);
        n = 0;
        while (err && n < 100) begin n++; tick(); end
        chk("err_len", n, HOLD);
        chk("err_sum", int'(sum), 5);
        chk("err_candy", int'(candy_sum), 3);
        chk("err_busy", int'(busy), 0);
        press(4'hE); chk("cancel_cv", int'(change_valid), 1);
        chk("cancel_amt", int'(change_amt), 5);
        tick();

        // Dispense candy 2 from 50, change 30
        press(4'hC); press(4'hC); press(4'h2);
        chk("sum50", int'(sum), 50);
        press(4'hF); chk("disp", int'(dispense), 1);
        chk("disp_id", int'(dispense_id), 2);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (change_valid) found = 1;
        end
        chk("chg_seen", found, 1);
        chk("chg_amt", int'(change_amt), 30);
        tick();
        chk("post_sum", int'(sum), 0);
        chk("post_candy", int'(candy_sum), 0);
        chk("post_busy", int'(busy), 0);

        // Exact payment: no change pulse; coin during DISPENSE dropped
        press(4'hB); press(4'hA); press(4'h1);
        press(4'hF); chk("exact_disp", int'(dispense), 1);
        press(4'hC); chk("disp_coin_sum", int'(sum), 0);
        wait_idle(saw);
        chk("exact_no_cv", saw, 0);
        chk("exact_amt", int'(change_amt), 0);
        tick();

        // Credit ceiling
        for (int i = 0; i < 8; i++) press(4'hC);
        chk("sum200", int'(sum), 200);
        press(4'hC); chk("reject", int'(coin_reject), 1);
        chk("sum_hold", int'(sum), 200);
        press(4'hE); chk("refund_cv", int'(change_valid), 1);
        chk("refund_amt", int'(change_amt), 200);
        tick();
        chk("refund_idle", int'(sum), 0);

        // Confirm with no selection; coin during ERROR dropped
        press(4'hA);
        press(4'hF); chk("nosel_err", int'(err), 1);
        press(4'hC); chk("err_coin_sum", int'(sum), 5);
        wait_idle(saw);
        press(4'hE); tick();

        // Reset two cycles into DISPENSE
        press(4'hC); press(4'hC); press(4'h1);
        press(4'hF); chk("rd_disp", int'(dispense), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rd_busy", int'(busy), 0);
        chk("rd_sum", int'(sum), 0);
        chk("rd_cv", int'(change_valid), 0);
        chk("rd_candy", int'(candy_sum), 0);
        for (int i = 0; i < 2 * HOLD; i++) tick();
        chk("rd_stay_idle", int'(change_valid | busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
